// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the CPU data side and dmem_responder.
// The master drives the request and the slave answers with a one-cycle resp.
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        proto_err;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_resp,
    input  mem_rdata,
    input  busy,
    input  proto_err
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_resp,
    output mem_rdata,
    output busy,
    output proto_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM answering the CPU data port after a fixed latency.
// The request is latched on acceptance; later request changes only flag proto_err.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input logic         clk,
  input logic         reset,
  dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int          W        = DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  logic [15:0] ram [2**W];

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [W-1:0] idx;
  logic [15:0] wdata;
  logic [1:0]  be;

  logic        resp_q;
  logic [15:0] rdata_q;
  logic        busy_q;
  logic        err_q;

  logic         req;
  logic [W-1:0] cur_idx;
  logic         changed;
  logic         addr_unused;

  assign req     = bus.mem_read | bus.mem_write;
  assign cur_idx = bus.mem_address[W:1];
  assign changed = (bus.mem_write != op_wr) || (cur_idx != idx);
  assign addr_unused = ^{bus.mem_address[15:W+1], bus.mem_address[0]};

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.proto_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      idx     <= '0;
      wdata   <= '0;
      be      <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            // Read+write together resolves to a write.
            op_wr <= bus.mem_write;
            idx   <= cur_idx;
            wdata <= bus.mem_wdata;
            be    <= bus.mem_byte_enable;
            cnt   <= CNT_INIT;
            if (bus.mem_read && bus.mem_write) err_q <= 1'b1;
            if (LATENCY == 1) begin
              state  <= RESP;
              resp_q <= 1'b1;
              if (!bus.mem_write) rdata_q <= ram[cur_idx];
            end else begin
              state  <= ACCESS;
              busy_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
            cnt    <= '0;
          end else begin
            if (changed) err_q <= 1'b1;
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state  <= RESP;
              busy_q <= 1'b0;
              resp_q <= 1'b1;
              if (!op_wr) rdata_q <= ram[idx];
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write commits on the edge that ends RESP; reset leaves state != RESP.
  always_ff @(posedge clk) begin
    if (state == RESP && op_wr) begin
      if (be[0]) ram[idx][7:0]  <= wdata[7:0];
      if (be[1]) ram[idx][15:8] <= wdata[15:8];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=3 main instance
// plus a LATENCY=1 instance for the single-cycle path.
module tb_dmem_responder;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  dmem_responder #(.DEPTH_LOG2(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int n0;
  logic [15:0] sb [$];

  always @(negedge clk) if (bus.mem_resp) resp_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = a;
    bus.mem_wdata       = d;
    bus.mem_byte_enable = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic drive1(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    bus1.mem_read        = rd;
    bus1.mem_write       = wr;
    bus1.mem_address     = a;
    bus1.mem_wdata       = d;
    bus1.mem_byte_enable = be;
  endtask

  // Drives one request now and follows it to its resp; leaves it asserted.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        input logic [15:0] exp, input int exp_cyc);
    bit seen = 0;
    drive(rd, wr, a, d, be);
    if (rd && !wr) sb.push_back(exp);
    for (int c = 1; c <= exp_cyc + 4 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        seen = 1;
        chk("resp_cycle", c, exp_cyc);
        chk("busy_in_resp", {31'b0, bus.busy}, 0);
        if (rd && !wr) begin
          if (sb.size() == 0) chk("sb_empty", 0, 1);
          else chk("rdata", {16'b0, bus.mem_rdata}, {16'b0, sb.pop_front()});
        end
      end else begin
        chk("busy", {31'b0, bus.busy},
            {31'b0, (c > exp_cyc - LAT) && (c < exp_cyc)});
      end
    end
    if (!seen) chk("resp_timeout", 0, 1);
  endtask

  task automatic op(input bit rd, input bit wr, input logic [15:0] a,
                    input logic [15:0] d, input logic [1:0] be,
                    input logic [15:0] exp);
    access(rd, wr, a, d, be, exp, LAT);
    idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    drive1(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    #2;
    chk("rst_resp", {31'b0, bus.mem_resp}, 0);
    chk("rst_rdata", {16'b0, bus.mem_rdata}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_err", {31'b0, bus.proto_err}, 0);
    chk("rst_resp1", {31'b0, bus1.mem_resp}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    op(0, 1, 16'h0010, 16'hBEEF, 2'b11, 16'h0);
    op(1, 0, 16'h0010, 16'h0, 2'b00, 16'hBEEF);

    op(0, 1, 16'h0020, 16'h1234, 2'b11, 16'h0);
    op(0, 1, 16'h0020, 16'hABCD, 2'b01, 16'h0);
    op(1, 0, 16'h0020, 16'h0, 2'b00, 16'h12CD);
    op(0, 1, 16'h0020, 16'hABCD, 2'b10, 16'h0);
    op(1, 0, 16'h0020, 16'h0, 2'b00, 16'hABCD);
    op(0, 1, 16'h0020, 16'h0000, 2'b00, 16'h0);
    op(1, 0, 16'h0020, 16'h0, 2'b00, 16'hABCD);

    op(0, 1, 16'h0030, 16'h0040, 2'b11, 16'h0);
    op(0, 1, 16'h0040, 16'h5555, 2'b11, 16'h0);
    n0 = resp_cnt;
    access(1, 0, 16'h0030, 16'h0, 2'b00, 16'h0040, LAT);
    access(1, 0, 16'h0040, 16'h0, 2'b00, 16'h5555, LAT + 1);
    idle();
    repeat (3) @(negedge clk);
    chk("ldi_pulses", resp_cnt - n0, 2);

    op(0, 1, 16'h0202, 16'h0F0F, 2'b11, 16'h0);
    op(1, 0, 16'h0002, 16'h0, 2'b00, 16'h0F0F);
    chk("err_clean", {31'b0, bus.proto_err}, 0);

    op(0, 1, 16'h0050, 16'h7777, 2'b11, 16'h0);
    n0 = resp_cnt;
    drive(1'b0, 1'b1, 16'h0050, 16'h9999, 2'b11);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    chk("abort_no_resp", resp_cnt - n0, 0);
    chk("abort_err", {31'b0, bus.proto_err}, 1);
    op(1, 0, 16'h0050, 16'h0, 2'b00, 16'h7777);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("err_cleared", {31'b0, bus.proto_err}, 0);
    @(negedge clk);
    op(1, 1, 16'h0070, 16'h4242, 2'b11, 16'h0);
    chk("conflict_err", {31'b0, bus.proto_err}, 1);
    op(1, 0, 16'h0070, 16'h0, 2'b00, 16'h4242);
    repeat (4) @(negedge clk);
    chk("err_sticky", {31'b0, bus.proto_err}, 1);

    op(0, 1, 16'h0060, 16'h1111, 2'b11, 16'h0);
    op(1, 0, 16'h0060, 16'h0, 2'b00, 16'h1111);
    drive(1'b0, 1'b1, 16'h0060, 16'h2222, 2'b11);
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'b0, bus.busy}, 1);
    reset = 1'b1;
    #1;
    chk("arst_resp", {31'b0, bus.mem_resp}, 0);
    chk("arst_busy", {31'b0, bus.busy}, 0);
    chk("arst_rdata", {16'b0, bus.mem_rdata}, 0);
    chk("arst_err", {31'b0, bus.proto_err}, 0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    op(1, 0, 16'h0060, 16'h0, 2'b00, 16'h1111);

    drive1(1'b0, 1'b1, 16'h0006, 16'hC3A5, 2'b11);
    @(negedge clk);
    chk("l1_wr_resp", {31'b0, bus1.mem_resp}, 1);
    chk("l1_wr_busy", {31'b0, bus1.busy}, 0);
    drive1(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);
    chk("l1_idle_resp", {31'b0, bus1.mem_resp}, 0);
    drive1(1'b1, 1'b0, 16'h0006, 16'h0, 2'b00);
    @(negedge clk);
    chk("l1_rd_resp", {31'b0, bus1.mem_resp}, 1);
    chk("l1_rdata", {16'b0, bus1.mem_rdata}, 32'h0000C3A5);
    drive1(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
